// File: rtl/btn_debounce_ctrl_pkg.sv
// Shared constants for the push-button debounce controller: FSM state
// encodings and default timing values (50 MHz system clock).
package btn_debounce_ctrl_pkg;

  // FSM state encodings (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESSED      = 2'd1;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd2;

  // 20 ms debounce window and 1 s long-press window at 50 MHz
  localparam int DB_COUNT_DEF   = 1000000;
  localparam int LONG_COUNT_DEF = 50000000;
  localparam int CNT_W_DEF      = 21;

endpackage

// File: rtl/btn_debounce_ctrl_debounce.sv
// debounce_cell: 2-flop synchronizer followed by a stability counter.
// 'change' is high in the cycle before 'stable' takes the new level, so a
// consumer can register an event on the same edge that 'stable' moves.
module debounce_cell
  import btn_debounce_ctrl_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic change
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronized input has differed from 'stable' for DB_COUNT cycles
  assign change = (sync2 != stable) && (cnt == DB_LAST);

  // Synchronize the raw input and count consecutive cycles of disagreement
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of the others (sync1 -> sync2 chain).
    if (reset) begin
      // NOTE: the synchronizer flops are cleared too, so a count in flight
      // at reset is fully discarded and a held button is re-debounced.
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (change) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_debounce_ctrl.sv
// btn_debounce_ctrl: debounced push-button with press strobe, mode toggle
// ('check') and switch capture. Optional long-press detection is enabled
// by defining BTN_LONG_PRESS_EN; without it long_pulse is tied low and no
// hold counter exists.
module btn_debounce_ctrl
  import btn_debounce_ctrl_pkg::*;
#(
  parameter int DB_COUNT   = DB_COUNT_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LONG_COUNT = LONG_COUNT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  input  logic [7:0] sw_in,
  output logic       check,
  output logic       press_pulse,
  output logic [7:0] sw_val,
  output logic       btn_stable,
  output logic       long_pulse
);

  // Reject degenerate timing at elaboration
  if (DB_COUNT < 1 || LONG_COUNT < 1) begin : g_param_err
    $error("btn_debounce_ctrl: DB_COUNT and LONG_COUNT must be at least 1");
  end

  logic       btn_change;
  logic [7:0] sw_s1;
  logic [7:0] sw_s2;
  logic [1:0] state;

  debounce_cell #(
    .DB_COUNT (DB_COUNT),
    .CNT_W    (CNT_W)
  ) u_btn_db (
    .clk    (clk),
    .reset  (reset),
    .din    (btn_in),
    .stable (btn_stable),
    .change (btn_change)
  );

  // Switches are level inputs sampled only at a press: synchronize, no debounce
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1 <= 8'h00;
      sw_s2 <= 8'h00;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int HOLD_W = (CNT_W > $clog2(LONG_COUNT)) ? CNT_W : $clog2(LONG_COUNT);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_COUNT - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              long_done;
`else
  assign long_pulse = 1'b0;
`endif

  // Press FSM: act on the debounced edge, update check/sw_val on a press only
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      check       <= 1'b0;
      press_pulse <= 1'b0;
      sw_val      <= 8'h00;
`ifdef BTN_LONG_PRESS_EN
      long_pulse  <= 1'b0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
`endif
    end else begin
      press_pulse <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
      long_pulse  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
`ifdef BTN_LONG_PRESS_EN
          hold_cnt  <= '0;
          long_done <= 1'b0;
`endif
          // Rising debounced edge: btn_stable goes high on this same edge
          if (btn_change && !btn_stable) begin
            state       <= ST_PRESSED;
            press_pulse <= 1'b1;
            check       <= ~check;
            sw_val      <= sw_s2;
          end
        end
        ST_PRESSED: begin
`ifdef BTN_LONG_PRESS_EN
          // One long-press event per hold; the counter freezes afterwards
          if (!long_done) begin
            if (hold_cnt == LONG_LAST) begin
              long_pulse <= 1'b1;
              check      <= 1'b0;
              long_done  <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
`endif
          if (btn_change && btn_stable) begin
            state <= ST_RELEASE_WAIT;
          end
        end
        ST_RELEASE_WAIT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Directed bench for btn_debounce_ctrl with DB_COUNT=4, LONG_COUNT=10.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_btn_debounce_ctrl;

`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic [7:0] sw_in;
  logic       mode_check;
  logic       press_pulse;
  logic [7:0] sw_val;
  logic       btn_stable;
  logic       long_pulse;

  int   checks = 0;
  int   errors = 0;
  logic exp_check;

  btn_debounce_ctrl #(
    .DB_COUNT   (4),
    .CNT_W      (8),
    .LONG_COUNT (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .sw_in       (sw_in),
    .check       (mode_check),
    .press_pulse (press_pulse),
    .sw_val      (sw_val),
    .btn_stable  (btn_stable),
    .long_pulse  (long_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_check"}, 8'(mode_check), 8'h00);
    check({tag, "_press"}, 8'(press_pulse), 8'h00);
    check({tag, "_long"}, 8'(long_pulse), 8'h00);
    check({tag, "_stable"}, 8'(btn_stable), 8'h00);
    check({tag, "_swval"}, sw_val, 8'h00);
  endtask

  // Clean press: pulse after the 6th edge, short hold, clean release
  task automatic press_release(input string tag, input logic [7:0] sw);
    sw_in  = sw;
    btn_in = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check({tag, "_press"}, 8'(press_pulse), 8'(i == 6));
      if (i == 6) begin
        exp_check = ~exp_check;
        check({tag, "_check"}, 8'(mode_check), 8'(exp_check));
        check({tag, "_swval"}, sw_val, sw);
        check({tag, "_stable"}, 8'(btn_stable), 8'h01);
      end
    end
    btn_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check({tag, "_rel_press"}, 8'(press_pulse), 8'h00);
    end
    check({tag, "_rel_check"}, 8'(mode_check), 8'(exp_check));
    check({tag, "_rel_swval"}, sw_val, sw);
    check({tag, "_rel_stable"}, 8'(btn_stable), 8'h00);
  endtask

  initial begin
    reset     = 1'b1;
    btn_in    = 1'b0;
    sw_in     = 8'hA5;
    exp_check = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset_state("rst");

    // Clean press held 20 cycles; long press fires only when enabled
    btn_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("clean_press", 8'(press_pulse), 8'(i == 6));
      check("clean_long", 8'(long_pulse), 8'(LONG_EN && i == 16));
      if (i == 6) begin
        exp_check = 1'b1;
        check("clean_check", 8'(mode_check), 8'(exp_check));
        check("clean_swval", sw_val, 8'hA5);
        check("clean_stable", 8'(btn_stable), 8'h01);
      end
      if (LONG_EN && i == 16) exp_check = 1'b0;
    end
    btn_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("clean_rel_press", 8'(press_pulse), 8'h00);
      check("clean_rel_stable", 8'(btn_stable), 8'(i < 6));
    end
    check("clean_rel_check", 8'(mode_check), 8'(exp_check));
    check("clean_rel_swval", sw_val, 8'hA5);

    // Bounce: 1,1,0 then held; accept 4 stable cycles plus sync delay
    sw_in  = 8'h5A;
    btn_in = 1'b1;
    step();
    check("bounce_a", 8'(press_pulse), 8'h00);
    step();
    check("bounce_b", 8'(press_pulse), 8'h00);
    btn_in = 1'b0;
    step();
    check("bounce_c", 8'(press_pulse), 8'h00);
    btn_in = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      step();
      check("bounce_press", 8'(press_pulse), 8'(j == 6));
      check("bounce_stable", 8'(btn_stable), 8'(j >= 6));
    end
    exp_check = ~exp_check;
    check("bounce_check", 8'(mode_check), 8'(exp_check));
    check("bounce_swval", sw_val, 8'h5A);
    btn_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("bounce_rel_press", 8'(press_pulse), 8'h00);
      check("bounce_rel_long", 8'(long_pulse), 8'h00);
    end

    // Two separate presses: check toggles twice, sw_val tracks last press
    press_release("two_a", 8'h3C);
    press_release("two_b", 8'hC3);

    // Reset mid-debounce (counter at 2) with button held
    sw_in  = 8'h96;
    btn_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("mid_db_press", 8'(press_pulse), 8'h00);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_check = 1'b0;
    check_reset_state("mid_db_rst");
    for (int j = 1; j <= 7; j++) begin
      step();
      check("mid_db_redo", 8'(press_pulse), 8'(j == 6));
    end
    exp_check = 1'b1;
    check("mid_db_check", 8'(mode_check), 8'(exp_check));
    check("mid_db_swval", sw_val, 8'h96);

    // Reset mid-press with button held through: re-debounced as a new press
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_check = 1'b0;
    check_reset_state("mid_press_rst");
    for (int j = 1; j <= 7; j++) begin
      step();
      check("mid_press_redo", 8'(press_pulse), 8'(j == 6));
    end
    exp_check = 1'b1;
    check("mid_press_check", 8'(mode_check), 8'(exp_check));
    btn_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("mid_press_rel", 8'(press_pulse), 8'h00);
    end

    // 30-cycle hold from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_check = 1'b0;
    btn_in = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      check("hold_press", 8'(press_pulse), 8'(i == 6));
      check("hold_long", 8'(long_pulse), 8'(LONG_EN && i == 16));
    end
    exp_check = LONG_EN ? 1'b0 : 1'b1;
    check("hold_check", 8'(mode_check), 8'(exp_check));
    btn_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("hold_rel_press", 8'(press_pulse), 8'h00);
      check("hold_rel_long", 8'(long_pulse), 8'h00);
    end
    check("hold_rel_check", 8'(mode_check), 8'(exp_check));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
